// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and types shared by the RV32I pipeline stages.
// No ports; provides XLEN, the canonical NOP, a zero word and the default reset PC.
package rv32_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t INST_NOP         = 32'h0000_0013;
    localparam word_t ZERO_WORD        = '0;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch result: the PC it came from and the instruction word.
    typedef struct packed {
        word_t addr;
        word_t inst;
    } fetch_entry_t;

    // Word-align an address; misaligned fetch targets are not supported.
    function automatic word_t align_word(input word_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: generic synchronous FIFO, flushable, power-of-two DEPTH.
// Ports: clk, rst (sync active-low), flush, push/wdata, pop/rdata, full, empty, count.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                (do_push && !do_pop): cnt <= cnt + 1'b1;
                (do_pop && !do_push): cnt <= cnt - 1'b1;
                default:              cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (!(push && full && !pop))
                else $error("fetch_fifo: push into full FIFO");
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage; owns the PC, issues word fetches on a
// req/gnt/rvalid bus, buffers responses and hands them to decode with valid/ready.
// Ports: clk, rst (sync active-low); ibus_req_o/addr_o/gnt_i/rvalid_i/rdata_i;
// jump_en_i/jump_addr_i redirect from EX; id_ready_i, inst_valid_o/inst_o/inst_addr_o.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        id_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    word_t         pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic          run;

    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_empty;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_wdata;

    logic [CW-1:0] tag_count;
    logic          tag_full;
    logic          tag_empty;
    word_t         tag_head;

    logic [CW:0]   credit;
    logic          issue;
    logic          resp;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop;

    // Buffered plus in-flight fetches may never exceed the buffer size,
    // so every response always has a slot waiting for it.
    assign credit      = {1'b0, buf_count} + {1'b0, outstanding};
    assign ibus_req_o  = run && !jump_en_i
                      && (credit < (CW+1)'(FIFO_DEPTH));
    assign ibus_addr_o = pc;
    assign issue       = ibus_req_o && ibus_gnt_i;

    // A response with nothing outstanding is a straggler from before reset.
    assign resp        = ibus_rvalid_i && (outstanding != '0);
    assign resp_keep   = resp && (drop == '0);
    assign resp_drop   = resp && (drop != '0);

    assign buf_wdata   = '{addr: tag_head, inst: ibus_rdata_i};

    assign inst_valid_o = !buf_empty && !jump_en_i;
    assign inst_o       = inst_valid_o ? buf_head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? buf_head.addr : ZERO_WORD;
    assign pop          = inst_valid_o && id_ready_i;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_en_i),
        .push  (resp_keep),
        .wdata (buf_wdata),
        .pop   (pop),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // PC of every live request, in issue order, matched to responses.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .flush (jump_en_i),
        .push  (issue),
        .wdata (pc),
        .pop   (resp_keep),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= align_word(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
            run         <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (jump_en_i) begin
                pc   <= align_word(jump_addr_i);
                // Everything still in flight after this cycle is stale.
                drop <= outstanding - CW'(resp);
            end else begin
                if (issue)     pc   <= pc + 32'd4;
                if (resp_drop) drop <= drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && run) begin
            assert (!(ibus_rvalid_i && outstanding == '0))
                else $error("fetch_unit: rvalid with nothing outstanding");
            assert (!(resp_keep && buf_full && !pop))
                else $error("fetch_unit: response into full buffer");
            assert (!(issue && tag_full))
                else $error("fetch_unit: tag queue overflow");
            assert (!(resp_keep && tag_empty))
                else $error("fetch_unit: response without tag");
            assert ((tag_count + drop) == outstanding)
                else $error("fetch_unit: tag/drop/outstanding mismatch");
        end
    end

endmodule
